// File: rtl/dd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dd_pkg
// Description : Shared types and helpers for the DoubleDabble arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dd_pkg;

    // Arbiter sequencing states; encoding fixed so waveforms read consistently
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DELIVER = 3'd4
    } state_t;

    // One packed BCD digit
    typedef logic [3:0] bcd_digit_t;

    // Digit count presented by the converter for an n-bit operand
    function automatic int bcd_digits(input int n);
        return 2 * (n + 2) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after the pointer, wrapping past NREQ-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int  NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    localparam logic [IW:0] c_nreq = (IW + 1)'(NREQ);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Scan NREQ candidates starting at the pointer; first hit wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(i);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            w_cand = w_sum[IW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dd_arbiter
// Description : Round-robin scheduler sharing one DoubleDabble converter among
//               NREQ requesters, with a watchdog that aborts stuck conversions.
// Revision    : 1.0 - initial release
// ============================================================================
module dd_arbiter
    import dd_pkg::*;
#(
    parameter int  N       = 32,
    parameter int  NREQ    = 4,
    parameter int  TIMEOUT = 255,
    localparam int ND      = bcd_digits(N)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ-1:0][N-1:0]    ReqV,
    output logic [NREQ-1:0]           Gnt,
    output logic [NREQ-1:0]           Done,
    output bcd_digit_t [ND-1:0]       RspBCD,
    output logic                      RspErr,
    output logic                      Busy,
    output logic                      DdStart,
    output logic [N-1:0]              DdV,
    input  bcd_digit_t [ND-1:0]       DdBCD,
    input  logic                      DdReady
);

    localparam int c_iw = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_ww = $clog2(TIMEOUT + 1);
    // Abort fires one cycle early so the watchdog reaches TIMEOUT on the edge
    // that enters DELIVER, placing Done exactly TIMEOUT cycles after LAUNCH.
    localparam logic [c_ww-1:0] c_wd_last  = c_ww'(TIMEOUT - 1);
    // Watchdog value two cycles after the Start edge; Ready still high here
    // means a zero-latency converter.
    localparam logic [c_ww-1:0] c_zero_lat = c_ww'(3);
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(NREQ - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_land;
    logic                w_abort;

    logic [NREQ-1:0]     w_pick_oh;
    logic [c_iw-1:0]     w_pick_idx;
    logic                w_pick_any;

    logic [c_iw-1:0]     r_win;
    logic [NREQ-1:0]     r_win_oh;
    logic [c_iw-1:0]     r_ptr;
    logic [c_ww-1:0]     r_wdog;
    logic [N-1:0]        r_dv;
    logic [NREQ-1:0]     r_gnt;
    logic                r_start;
    logic [NREQ-1:0]     r_done;
    bcd_digit_t [ND-1:0] r_bcd;
    logic                r_err;

    rr_pick #(
        .NREQ    (NREQ)
    ) u_pick (
        .i_req   (Req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, plus which way a conversion finished
    always_comb begin
        w_next  = r_state;
        w_land  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any && DdReady) begin
                    w_next = LAUNCH;
                end
            end
            LAUNCH: begin
                w_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (r_wdog == c_wd_last) begin
                    w_abort = 1'b1;
                    w_next  = DELIVER;
                end else if (!DdReady || r_wdog >= c_zero_lat) begin
                    w_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (DdReady) begin
                    w_land = 1'b1;
                    w_next = DELIVER;
                end else if (r_wdog == c_wd_last) begin
                    w_abort = 1'b1;
                    w_next  = DELIVER;
                end
            end
            DELIVER: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Winner capture, pulse outputs, watchdog and response latching
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_win    <= '0;
            r_win_oh <= '0;
            r_ptr    <= '0;
            r_wdog   <= '0;
            r_dv     <= '0;
            r_gnt    <= '0;
            r_start  <= 1'b0;
            r_done   <= '0;
            r_bcd    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_start <= 1'b0;
            r_done  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_next == LAUNCH) begin
                        r_win    <= w_pick_idx;
                        r_win_oh <= w_pick_oh;
                        r_dv     <= ReqV[w_pick_idx];
                        r_wdog   <= '0;
                    end
                end
                LAUNCH: begin
                    r_gnt   <= r_win_oh;
                    r_start <= 1'b1;
                    r_ptr   <= (r_win == c_last_idx) ? '0 : r_win + 1'b1;
                    r_wdog  <= r_wdog + 1'b1;
                end
                WAIT_LO, WAIT_HI: begin
                    r_wdog <= r_wdog + 1'b1;
                end
                default: begin
                end
            endcase
            if (w_land) begin
                r_bcd  <= DdBCD;
                r_err  <= 1'b0;
                r_done <= r_win_oh;
            end else if (w_abort) begin
                r_bcd  <= '0;
                r_err  <= 1'b1;
                r_done <= r_win_oh;
            end
        end
    end

    assign Gnt     = r_gnt;
    assign Done    = r_done;
    assign DdStart = r_start;
    assign DdV     = r_dv;
    assign RspBCD  = r_bcd;
    assign RspErr  = r_err;
    assign Busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dd_arbiter
// Description : Self-checking bench for dd_arbiter with a behavioural
//               converter and a round-robin / decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dd_arbiter;
    import dd_pkg::*;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int TMO  = 20;
    localparam int ND   = bcd_digits(N);

    typedef bcd_digit_t [ND-1:0] bcd_vec_t;

    logic                   Clock = 1'b0;
    logic                   Reset = 1'b1;
    logic [NREQ-1:0]        Req   = '0;
    logic [NREQ-1:0][N-1:0] ReqV  = '0;
    logic [NREQ-1:0]        Gnt;
    logic [NREQ-1:0]        Done;
    bcd_vec_t               RspBCD;
    logic                   RspErr;
    logic                   Busy;
    logic                   DdStart;
    logic [N-1:0]           DdV;
    bcd_vec_t               DdBCD   = '0;
    logic                   DdReady = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ref_ptr = 0;

    int         cv_mode = 0;   // 0 normal, 1 Ready stuck low, 2 zero latency
    int         cv_lat  = 5;
    int         cv_cnt  = 0;
    logic [N-1:0] cv_val = '0;

    int   n_start  = 0;
    int   n_done   = 0;
    int   n_gnt1   = 0;
    int   rise_cyc = -1;
    logic prev_rdy = 1'b1;

    dd_arbiter #(
        .N       (N),
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .ReqV    (ReqV),
        .Gnt     (Gnt),
        .Done    (Done),
        .RspBCD  (RspBCD),
        .RspErr  (RspErr),
        .Busy    (Busy),
        .DdStart (DdStart),
        .DdV     (DdV),
        .DdBCD   (DdBCD),
        .DdReady (DdReady)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Decimal digits of a value, least significant digit first
    function automatic bcd_vec_t to_bcd(input logic [N-1:0] v);
        bcd_vec_t r;
        longint   x;
        r = '0;
        x = {32'd0, v};
        for (int d = 0; d < ND; d++) begin
            r[d] = 4'(x % 10);
            x    = x / 10;
        end
        return r;
    endfunction

    // First pending requester at or after the pointer, wrapping
    function automatic int rr_expect(input logic [NREQ-1:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural converter
    always @(posedge Clock) begin
        if (DdStart) begin
            cv_val <= DdV;
            if (cv_mode == 2) begin
                DdBCD <= to_bcd(DdV);
            end else begin
                DdReady <= 1'b0;
                cv_cnt  <= cv_lat;
            end
        end else if (cv_mode == 0 && !DdReady) begin
            if (cv_cnt <= 1) begin
                DdReady <= 1'b1;
                DdBCD   <= to_bcd(cv_val);
            end else begin
                cv_cnt <= cv_cnt - 1;
            end
        end
    end

    // Event counters sampled mid-cycle
    always @(negedge Clock) begin
        if (DdStart) n_start++;
        if (Done != '0) n_done++;
        if (Gnt[1]) n_gnt1++;
        if (DdReady && !prev_rdy) rise_cyc = cyc;
        prev_rdy = DdReady;
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int k = 0; k < 200 && idx < 0; k++) begin
            step();
            for (int b = 0; b < NREQ; b++) if (Gnt[b]) idx = b;
        end
    endtask

    task automatic wait_done(output int idx);
        idx = -1;
        for (int k = 0; k < 200 && idx < 0; k++) begin
            step();
            for (int b = 0; b < NREQ; b++) if (Done[b]) idx = b;
        end
    endtask

    // Hold a set of requests and check every grant and response
    task automatic serve(input logic [NREQ-1:0] mask, input string tag);
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] oh;
        int w, e, d;
        pend = mask;
        Req  = mask;
        while (pend != '0) begin
            wait_gnt(w);
            e = rr_expect(pend, ref_ptr);
            n_cmp++;
            if (w != e) begin
                n_bad++;
                $display("FAIL %s grant: got %0d want %0d", tag, w, e);
            end
            if (w < 0) begin
                Req = '0;
                return;
            end
            ref_ptr = (w + 1) % NREQ;
            n_cmp++;
            if (DdStart !== 1'b1 || DdV !== ReqV[w]) begin
                n_bad++;
                $display("FAIL %s launch: start=%b dv=%h want start=1 dv=%h", tag, DdStart, DdV, ReqV[w]);
            end
            Req[w]  = 1'b0;
            pend[w] = 1'b0;
            oh      = '0;
            oh[w]   = 1'b1;
            wait_done(d);
            n_cmp++;
            if (Done !== oh || RspBCD !== to_bcd(ReqV[w]) || RspErr !== 1'b0) begin
                n_bad++;
                $display("FAIL %s result: done=%b bcd=%h err=%b want done=%b bcd=%h err=0",
                         tag, Done, RspBCD, RspErr, oh, to_bcd(ReqV[w]));
            end
        end
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (Gnt !== '0 || Done !== '0 || DdStart !== 1'b0 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: gnt=%b done=%b start=%b busy=%b want all 0", Gnt, Done, DdStart, Busy);
        end
        n_cmp++;
        if (DdV !== '0 || RspBCD !== '0 || RspErr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data: dv=%h bcd=%h err=%b want 0", DdV, RspBCD, RspErr);
        end
        Reset = 1'b1;
        ref_ptr = 0;
        step();
    endtask

    task automatic test_single();
        int c0, w, d, s0;
        s0      = n_start;
        ReqV[0] = 32'd12345;
        c0      = cyc;
        Req     = 4'b0001;
        wait_gnt(w);
        n_cmp++;
        if (w != 0 || cyc - c0 != 2) begin
            n_bad++;
            $display("FAIL single_gnt: idx=%0d latency=%0d want idx=0 latency=2", w, cyc - c0);
        end
        n_cmp++;
        if (DdStart !== 1'b1 || DdV !== 32'd12345) begin
            n_bad++;
            $display("FAIL single_launch: start=%b dv=%0d want 1/12345", DdStart, DdV);
        end
        Req = '0;
        ref_ptr = 1;
        wait_done(d);
        n_cmp++;
        if (Done !== 4'b0001 || cyc != rise_cyc + 1) begin
            n_bad++;
            $display("FAIL single_done: done=%b at %0d ready_rise=%0d want 0001 one cycle later", Done, cyc, rise_cyc);
        end
        n_cmp++;
        if (RspBCD[4:0] !== {4'd1, 4'd2, 4'd3, 4'd4, 4'd5} || RspBCD[ND-1:5] !== '0 || RspErr !== 1'b0) begin
            n_bad++;
            $display("FAIL single_bcd: bcd=%h err=%b want ...012345 err=0", RspBCD, RspErr);
        end
        n_cmp++;
        if (n_start - s0 != 1) begin
            n_bad++;
            $display("FAIL single_starts: got %0d want 1", n_start - s0);
        end
    endtask

    task automatic test_max();
        int w, d;
        ReqV[2] = 32'hFFFF_FFFF;
        Req     = 4'b0100;
        wait_gnt(w);
        Req = '0;
        n_cmp++;
        if (w != 2) begin
            n_bad++;
            $display("FAIL max_gnt: idx=%0d want 2", w);
        end
        ref_ptr = 3;
        wait_done(d);
        n_cmp++;
        if (Done !== 4'b0100 || RspBCD !== to_bcd(32'hFFFF_FFFF) || RspErr !== 1'b0) begin
            n_bad++;
            $display("FAIL max_result: done=%b bcd=%h err=%b want 0100 4294967295", Done, RspBCD, RspErr);
        end
        step();
        n_cmp++;
        if (Busy !== 1'b0 || Done !== '0) begin
            n_bad++;
            $display("FAIL max_after: busy=%b done=%b want 0/0000", Busy, Done);
        end
    endtask

    task automatic test_round_robin();
        for (int b = 0; b < NREQ; b++) ReqV[b] = $urandom;
        serve(4'b1000, "rr_align");
        n_cmp++;
        if (ref_ptr != 0) begin
            n_bad++;
            $display("FAIL rr_align_ptr: model pointer %0d want 0", ref_ptr);
        end
        serve(4'b1111, "rr_all");
        serve(4'b1001, "rr_1001");
    endtask

    task automatic test_timeout();
        int w, d, l;
        cv_mode = 1;
        ReqV[1] = $urandom;
        Req     = 4'b0010;
        wait_gnt(w);
        Req = '0;
        l   = cyc - 1;
        ref_ptr = 2;
        n_cmp++;
        if (w != 1) begin
            n_bad++;
            $display("FAIL tmo_gnt: idx=%0d want 1", w);
        end
        wait_done(d);
        n_cmp++;
        if (Done !== 4'b0010 || cyc - l != TMO) begin
            n_bad++;
            $display("FAIL tmo_done: done=%b after %0d cycles want 0010 after %0d", Done, cyc - l, TMO);
        end
        n_cmp++;
        if (RspErr !== 1'b1 || RspBCD !== '0) begin
            n_bad++;
            $display("FAIL tmo_resp: err=%b bcd=%h want err=1 bcd=0", RspErr, RspBCD);
        end
        cv_mode = 0;
        ReqV[0] = $urandom;
        serve(4'b0001, "tmo_recover");
    endtask

    task automatic test_async_reset();
        int w, d0;
        cv_lat  = 15;
        ReqV[3] = $urandom_range(1, 999999);
        Req     = 4'b1000;
        wait_gnt(w);
        Req = '0;
        repeat (5) step();
        d0 = n_done;
        #2 Reset = 1'b0;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Gnt !== '0 || Done !== '0 || DdStart !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_ctrl: busy=%b gnt=%b done=%b start=%b want 0", Busy, Gnt, Done, DdStart);
        end
        n_cmp++;
        if (DdV !== '0 || RspBCD !== '0 || RspErr !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_data: dv=%h bcd=%h err=%b want 0", DdV, RspBCD, RspErr);
        end
        repeat (3) step();
        Reset   = 1'b1;
        ref_ptr = 0;
        repeat (20) step();
        n_cmp++;
        if (n_done != d0) begin
            n_bad++;
            $display("FAIL areset_nodone: %0d Done pulses want 0", n_done - d0);
        end
        cv_lat  = 5;
        ReqV[2] = '0;
        serve(4'b0100, "areset_rereq");
    endtask

    task automatic test_busy_ignore();
        int w, d, s0, g0;
        ReqV[0] = $urandom;
        ReqV[1] = $urandom;
        Req     = 4'b0001;
        wait_gnt(w);
        Req     = '0;
        ref_ptr = (w + 1) % NREQ;
        s0 = n_start;
        g0 = n_gnt1;
        step();
        Req = 4'b0010;
        step();
        Req = '0;
        wait_done(d);
        repeat (10) step();
        n_cmp++;
        if (d != 0 || n_start != s0 || n_gnt1 != g0) begin
            n_bad++;
            $display("FAIL busy_ignore: done_idx=%0d extra_starts=%0d gnt1=%0d want 0/0/0",
                     d, n_start - s0, n_gnt1 - g0);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        for (int it = 0; it < 12; it++) begin
            cv_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            cv_lat  = int'($urandom_range(3, 12));
            mask    = 4'($urandom_range(1, 15));
            for (int b = 0; b < NREQ; b++) ReqV[b] = $urandom;
            serve(mask, "random");
            step();
        end
        cv_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_max();
        test_round_robin();
        test_timeout();
        test_async_reset();
        test_busy_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dd_arbiter.md
Name: dd_arbiter

Overview:
Round-robin scheduler that shares one DoubleDabble binary-to-BCD converter among NREQ requesters. Takes the winning requester's value and pulses the converter's Start. Waits for Ready and latches BCD. Returns the result with a one-cycle Done pulse to the owning requester. A watchdog aborts a conversion that never completes.

Parameters:
N, 32, binary operand width (matches converter N)
NREQ, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles from Start to Ready before abort
ND, 2*(N+2)+1, BCD digits on converter port (derived, not overridable)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low; 0 forces reset state
Req  in  NREQ  per-requester request level
ReqV  in  NREQ x N  per-requester operand
Gnt  out  NREQ  one-hot 1-cycle pulse: operand accepted
Done  out  NREQ  one-hot 1-cycle pulse: RspBCD/RspErr valid
RspBCD  out  ND x 4  latched conversion result
RspErr  out  1  1 = timeout; valid with Done
Busy  out  1  1 whenever FSM not IDLE
DdStart  out  1  to converter Start
DdV  out  N  to converter V
DdBCD  in  ND x 4  from converter BCD
DdReady  in  1  from converter Ready

Behaviour:
- Converter contract: samples V on the edge where Start=1. Ready falls within 2 cycles. Ready rises when BCD is valid and holds until the next Start.
- Reset (Reset=0, async): state IDLE, rr pointer=0, wdog=0, Gnt=0, Done=0, DdStart=0, DdV=0, RspBCD=0, RspErr=0, Busy=0.
- FSM states: IDLE, LAUNCH, WAIT_LO, WAIT_HI, DELIVER.
- IDLE: if any Req and DdReady=1, pick the first set Req at or after the rr pointer (wrapping). Register the winner index and ReqV into DdV, then go to LAUNCH. If DdReady=0, stay in IDLE.
- LAUNCH (1 cycle): DdStart=1, Gnt[win]=1. rr pointer <= win+1 mod NREQ. Go to WAIT_LO. Clear wdog.
- WAIT_LO: wait for DdReady=0. If DdReady is still 1 after 2 cycles, treat it as a zero-latency converter and go to WAIT_HI.
- WAIT_HI: on DdReady=1, latch DdBCD into RspBCD, RspErr=0, go to DELIVER.
- Watchdog: wdog increments every cycle in WAIT_LO/WAIT_HI. At wdog==TIMEOUT, RspBCD=0, RspErr=1, go to DELIVER.
- DELIVER (1 cycle): Done[win]=1, return to IDLE. RspBCD/RspErr hold until the next DELIVER.
- Latency: Req to Gnt is 2 cycles when IDLE. Done arrives 1 cycle after DdReady rises.
- Requesters hold Req and ReqV stable until Gnt and drop Req the cycle after Gnt. A Req dropped before Gnt is simply not granted; no error.
- Req changes during WAIT are ignored; arbitration occurs only in IDLE.
- DdV stays constant from LAUNCH through DELIVER.
- Simultaneous Reqs: strict round-robin, no starvation. Worst-case wait is NREQ-1 conversions.
- Reset asserted mid-operation: immediate return to reset values with no Done. The requester must re-request.
- Gnt, Done and DdStart are registered outputs; there are no combinational paths from inputs to outputs.

Decomposition:
- Package dd_pkg:
  - typedef enum state_t {IDLE, LAUNCH, WAIT_LO, WAIT_HI, DELIVER}
  - function bcd_digits(N) returning 2*(N+2)+1
  - typedef for the BCD digit (logic [3:0])
- Sub-module rr_pick: combinational round-robin priority picker (Req, pointer in; one-hot winner and index out), reusable elsewhere.

Test Plan:
1. N=32, NREQ=4, real DoubleDabble attached. Req[0]=1, ReqV[0]=12345 → one DdStart pulse with DdV=12345, Gnt[0]; then Done[0] with RspBCD digits[4:0]=1,2,3,4,5, upper digits 0, RspErr=0.
2. ReqV[2]=32'hFFFFFFFF → RspBCD=4294967295, Done[2] only, Busy=0 the cycle after Done.
3. Req=4'b1111 held, each dropped after its Gnt → Gnt order 0,1,2,3. Then Req=4'b1001 with pointer at 0 → grants 0 then 3.
4. Stub converter with Ready stuck low, TIMEOUT=20 → Done[win] and RspErr=1 exactly 20 cycles after LAUNCH; RspBCD=0; next request is served normally.
5. Reset=0 driven asynchronously mid-WAIT_HI → all outputs 0 before the next edge, no Done. After release, re-request V=0 → RspBCD=0, Done pulse.
6. Req[1] raised for 1 cycle while Busy, then dropped → no Gnt[1] and no extra DdStart.
